dmem_ldst_unit: RTL
===================

# dmem_ldst_unit

Load/store sequencer between the core's execute stage and the single-port byte-wide data memory. It accepts one byte or halfword request per handshake and splits halfword accesses into two sequential byte accesses, little-endian. It drives the memory's address, write-enable and write-data inputs, consumes the memory's combinational read data, and returns a one-cycle response to the core.

## Interface
- A, 8: memory address width; memory depth is 2**A bytes
- W, 8: memory data width; halfword = 2W bits
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- ReqValid  in  1  core request valid
- ReqReady  out  1  unit can accept a request this cycle
- ReqWrite  in  1  1 = store, 0 = load
- ReqWide  in  1  1 = halfword (2 bytes), 0 = byte
- ReqAddr  in  A  byte address (low byte for halfword)
- ReqData  in  2W  store data; bits [W-1:0] only for byte stores
- RespValid  out  1  one-cycle pulse: request complete
- RespData  out  2W  load result; zero-extended for byte loads
- MemAddr  out  A  to memory address input
- MemWriteEn  out  1  to memory write enable
- MemDataIn  out  W  to memory write data
- MemDataOut  in  W  from memory; combinational read of Core[MemAddr]

## Operation
- States: IDLE, LO, HI.
- IDLE: ReqReady=1. On ReqValid at a clock edge, latch ReqWrite, ReqWide, ReqAddr, ReqData, and go to LO.
- LO: MemAddr = latched addr. Store: MemWriteEn=1, MemDataIn = data[W-1:0]. Load: capture MemDataOut into result[W-1:0] at end of cycle. Next state: HI if wide, else IDLE with response.
- HI: MemAddr = (addr+1) mod 2**A, so 0xFF wraps to 0x00. Store: MemWriteEn=1, MemDataIn = data[2W-1:W]. Load: capture into result[2W-1:W]. Next state: IDLE with response.
- Response: RespValid=1 for exactly one cycle, the first IDLE cycle after the final access.
  - Loads: RespData = result. Byte loads give {W'b0, byte}.
  - Stores: RespValid pulses, and RespData holds its previous value.
- ReqReady=0 in LO and HI. ReqValid in those states is ignored, and the core must hold the request.
- A new request may be accepted in the same cycle RespValid is high (back-to-back).
- MemWriteEn=0 in IDLE and on all load cycles.
- MemAddr and MemDataIn in IDLE hold their last driven values.
- Mem* outputs depend only on registered state, with no combinational path from Req* to Mem*.
- Reset has priority over all activity:
  - Next cycle: state IDLE, ReqReady=1, RespValid=0, RespData=0, MemWriteEn=0, MemAddr=0, MemDataIn=0, and all latches cleared.
  - Reset mid-operation aborts the request with no response. A halfword store reset in HI leaves the low byte written and the high byte unwritten.

## Timing
- Request accepted at edge k. LO is cycle k..k+1.
- Byte access: RespValid in cycle k+1..k+2.
- Halfword: HI in cycle k+1..k+2, RespValid in cycle k+2..k+3.
- Throughput: one byte op per 2 cycles, one halfword op per 3 cycles.
- Memory writes commit at the rising edge ending each LO/HI store cycle.
- Load data is sampled at the same edge. Memory read is combinational, so no extra wait state.

## Test plan
- Byte store 0xA5 to 0x10, then byte load 0x10:
  - Store: MemWriteEn high exactly one cycle, MemAddr=0x10.
  - Load: RespData=0x00A5, RespValid 2 cycles after acceptance.
- Halfword store 0xBEEF to 0x20, then halfword load 0x20:
  - Memory holds [0x20]=0xEF, [0x21]=0xBE.
  - Load returns RespData=0xBEEF, RespValid 3 cycles after acceptance.
- Halfword store 0x1234 to 0xFF: [0xFF]=0x34, [0x00]=0x12 (wrap). Halfword load from 0xFF returns 0x1234.
- Back-to-back: hold ReqValid for byte load 0x10 then byte load 0x11 in consecutive accepts.
  - ReqReady drops for exactly one cycle between them.
  - Second accept coincides with the first RespValid.
  - Both results are correct.
- Reset asserted during HI of a halfword store 0xCAFE to 0x30:
  - [0x30]=0xFE, [0x31] unchanged.
  - No RespValid; all outputs at reset values next cycle.
  - ReqReady=1.
- ReqValid toggled during LO/HI with different address: ignored, and the in-flight result is unchanged.

Source files
------------

// File: rtl/dmem_ldst_unit_if.sv
// Core-side request/response bus of the load/store unit.
// The core drives the request through master; the unit answers through slave.
interface dmem_ldst_unit_if #(
    parameter int A = 8,
    parameter int W = 8
);
    logic           ReqValid;
    logic           ReqReady;
    logic           ReqWrite;
    logic           ReqWide;
    logic [A-1:0]   ReqAddr;
    logic [2*W-1:0] ReqData;
    logic           RespValid;
    logic [2*W-1:0] RespData;

    modport master (
        output ReqValid, ReqWrite, ReqWide, ReqAddr, ReqData,
        input  ReqReady, RespValid, RespData
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqWide, ReqAddr, ReqData,
        output ReqReady, RespValid, RespData
    );
endinterface

// File: rtl/dmem_ldst_unit.sv
// Load/store sequencer for a byte-wide single-port data memory.
// Halfwords are split into two little-endian byte accesses (LO, then HI).
module dmem_ldst_unit #(
    parameter int A = 8,
    parameter int W = 8
) (
    input  logic            Clk,
    input  logic            Reset,
    dmem_ldst_unit_if.slave req,
    output logic [A-1:0]    MemAddr,
    output logic            MemWriteEn,
    output logic [W-1:0]    MemDataIn,
    input  logic [W-1:0]    MemDataOut
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    state_t         state_q, state_d;
    logic           write_q, write_d;
    logic           wide_q, wide_d;
    logic [A-1:0]   addr_q, addr_d;
    logic [W-1:0]   data_hi_q, data_hi_d;
    logic [W-1:0]   result_lo_q, result_lo_d;
    logic           resp_valid_q, resp_valid_d;
    logic [2*W-1:0] resp_data_q, resp_data_d;
    logic [A-1:0]   mem_addr_q, mem_addr_d;
    logic           mem_we_q, mem_we_d;
    logic [W-1:0]   mem_din_q, mem_din_d;

    // Next-state logic: memory outputs are set up one cycle ahead so they
    // come straight from flops during each access cycle.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        wide_d       = wide_q;
        addr_d       = addr_q;
        data_hi_d    = data_hi_q;
        result_lo_d  = result_lo_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_din_d    = mem_din_q;
        unique case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                if (req.ReqValid) begin
                    state_d    = LO;
                    write_d    = req.ReqWrite;
                    wide_d     = req.ReqWide;
                    addr_d     = req.ReqAddr;
                    data_hi_d  = req.ReqData[2*W-1:W];
                    mem_addr_d = req.ReqAddr;
                    mem_we_d   = req.ReqWrite;
                    mem_din_d  = req.ReqData[W-1:0];
                end
            end
            LO: begin
                if (!write_q) begin
                    result_lo_d = MemDataOut;
                end
                if (wide_q) begin
                    state_d    = HI;
                    mem_addr_d = addr_q + 1'b1;
                    mem_we_d   = write_q;
                    mem_din_d  = data_hi_q;
                end else begin
                    state_d      = IDLE;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!write_q) begin
                        resp_data_d = {{W{1'b0}}, MemDataOut};
                    end
                end
            end
            HI: begin
                state_d      = IDLE;
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                if (!write_q) begin
                    resp_data_d = {MemDataOut, result_lo_q};
                end
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared by synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            wide_q       <= 1'b0;
            addr_q       <= '0;
            data_hi_q    <= '0;
            result_lo_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            wide_q       <= wide_d;
            addr_q       <= addr_d;
            data_hi_q    <= data_hi_d;
            result_lo_q  <= result_lo_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_din_q    <= mem_din_d;
        end
    end

    // Reset blocks the write of the cycle it is raised in, so an access
    // aborted mid-flight never commits its pending byte.
    assign MemWriteEn    = mem_we_q & ~Reset;
    assign MemAddr       = mem_addr_q;
    assign MemDataIn     = mem_din_q;
    assign req.ReqReady  = (state_q == IDLE);
    assign req.RespValid = resp_valid_q;
    assign req.RespData  = resp_data_q;

endmodule
